// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared opcode, state and datapath mux encodings for the multicycle RV32I core
package rv_ctrl_pkg;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;
  typedef enum logic [3:0] {
    C_OP, C_OP_IMM, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL
  } iclass_t;
  typedef enum logic [1:0] {PC_PLUS4, PC_ALU, PC_ALU_LSB0} pc_src_t;
  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} alu_a_t;
  typedef enum logic [1:0] {B_RS2, B_IMM, B_FOUR} alu_b_t;
  typedef enum logic [1:0] {ALU_ADD, ALU_CMP, ALU_FUNCT} alu_op_t;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_t;
  function automatic iclass_t classify(input logic [6:0] opc);
    case (opc)
      OPC_OP_IMM: return C_OP_IMM;
      OPC_OP:     return C_OP;
      OPC_LOAD:   return C_LOAD;
      OPC_STORE:  return C_STORE;
      OPC_BRANCH: return C_BRANCH;
      OPC_JAL:    return C_JAL;
      OPC_JALR:   return C_JALR;
      OPC_LUI:    return C_LUI;
      OPC_AUIPC:  return C_AUIPC;
      default:    return C_ILL;
    endcase
  endfunction
endpackage

// File: rtl/rv_mem_wait_timer.sv
// rv_mem_wait_timer: counts memory wait cycles and flags the cycle on which the wait budget runs out
module rv_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= clr ? '0 : en ? cnt + 1'b1 : cnt;
  assign timeout = en && (cnt == CNT_W'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/rv_multicycle_controller.sv
// rv_multicycle_controller: multicycle RV32I control FSM sequencing fetch, decode, execute, memory and writeback
module rv_multicycle_controller
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_write,
  output logic       imm_en,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       illegal_instr,
  output logic       bus_error,
  output logic [2:0] state_o
);
  state_t state, nstate;
  iclass_t cls, ncls;
  logic phase, nphase, ill_set, bus_set, wait_en, timeout;
  logic unused_funct3;
  assign unused_funct3 = ^funct3;
  assign state_o = state;
  assign wait_en = (state == S_FETCH || state == S_MEM) && !mem_ready;
  rv_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clk(clk),
    .reset(reset),
    .clr(nstate != state),
    .en(wait_en),
    .timeout(timeout)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_FETCH;
      cls <= C_ILL;
      phase <= 1'b0;
      illegal_instr <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      state <= nstate;
      cls <= ncls;
      phase <= nphase;
      illegal_instr <= illegal_instr | ill_set;
      bus_error <= bus_error | bus_set;
    end
  always_comb begin
    nstate = state;
    ncls = cls;
    nphase = 1'b0;
    ill_set = 1'b0;
    bus_set = 1'b0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write = 1'b0;
    imm_en = 1'b0;
    pc_write = 1'b0;
    pc_src = PC_PLUS4;
    alu_src_a = A_RS1;
    alu_src_b = B_RS2;
    alu_op = ALU_ADD;
    reg_write = 1'b0;
    wb_sel = WB_ALU;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
        bus_set = timeout;
        nstate = mem_ready ? S_DECODE : timeout ? S_TRAP : S_FETCH;
      end
      S_DECODE: begin
        imm_en = 1'b1;
        ncls = classify(opcode);
        ill_set = ncls == C_ILL;
        nstate = ill_set ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        nstate = S_WB;
        case (cls)
          C_OP: alu_op = ALU_FUNCT;
          C_OP_IMM: begin
            alu_src_b = B_IMM;
            alu_op = ALU_FUNCT;
          end
          C_LOAD, C_STORE: begin
            alu_src_b = B_IMM;
            nstate = S_MEM;
          end
          C_BRANCH: begin
            alu_src_a = phase ? A_PC : A_RS1;
            alu_src_b = phase ? B_IMM : B_RS2;
            alu_op = phase ? ALU_ADD : ALU_CMP;
            pc_write = phase;
            pc_src = phase ? PC_ALU : PC_PLUS4;
            nphase = !phase && branch_taken;
            nstate = nphase ? S_EXEC : S_FETCH;
          end
          C_JAL: begin
            alu_src_a = A_PC;
            alu_src_b = B_IMM;
            pc_write = 1'b1;
            pc_src = PC_ALU;
          end
          C_JALR: begin
            alu_src_b = B_IMM;
            pc_write = 1'b1;
            pc_src = PC_ALU_LSB0;
          end
          C_LUI: begin
            alu_src_a = A_ZERO;
            alu_src_b = B_IMM;
          end
          C_AUIPC: begin
            alu_src_a = A_PC;
            alu_src_b = B_IMM;
          end
          default: nstate = S_TRAP;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we = cls == C_STORE;
        bus_set = timeout;
        nstate = mem_ready ? (cls == C_STORE ? S_FETCH : S_WB) : timeout ? S_TRAP : S_MEM;
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel = cls == C_LOAD ? WB_MEM : (cls == C_JAL || cls == C_JALR) ? WB_PC4 : WB_ALU;
        nstate = S_FETCH;
      end
      default: nstate = S_TRAP;
    endcase
    if (reset) begin
      mem_req = 1'b0;
      mem_we = 1'b0;
      mem_addr_sel = 1'b0;
      ir_write = 1'b0;
      imm_en = 1'b0;
      pc_write = 1'b0;
      pc_src = PC_PLUS4;
      alu_src_a = A_RS1;
      alu_src_b = B_RS2;
      alu_op = ALU_ADD;
      reg_write = 1'b0;
      wb_sel = WB_ALU;
    end
  end
endmodule

// File: tb/tb_rv_multicycle_controller.sv
// tb_rv_multicycle_controller: scoreboard bench replaying per-cycle expected control vectors
module tb_rv_multicycle_controller;
  logic clk = 1'b0, reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic branch_taken = 1'b0, mem_ready = 1'b0;
  logic mem_req, mem_we, mem_addr_sel, ir_write, imm_en, pc_write, reg_write, illegal_instr, bus_error;
  logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, wb_sel;
  logic [2:0] state_o;
  logic [21:0] obs;
  typedef struct {logic [6:0] opc; logic rdy; logic tk; logic [21:0] exp;} ent_t;
  ent_t sb[$];
  int checks = 0, failures = 0;
  localparam logic [6:0] ADDI = 7'b0010011, OP = 7'b0110011, LW = 7'b0000011, SW = 7'b0100011;
  localparam logic [6:0] BEQ = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, LUI = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111, BAD = 7'b1111111;
  rv_multicycle_controller #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_write(ir_write), .imm_en(imm_en), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .wb_sel(wb_sel), .illegal_instr(illegal_instr), .bus_error(bus_error), .state_o(state_o)
  );
  always #5 clk = ~clk;
  assign obs = {mem_req, mem_we, mem_addr_sel, ir_write, imm_en, pc_write, pc_src, alu_src_a,
                alu_src_b, alu_op, reg_write, wb_sel, illegal_instr, bus_error, state_o};
  function automatic logic [21:0] ev(input logic [2:0] st, input logic [5:0] ctl, input logic [1:0] pcs,
                                     input logic [1:0] a, input logic [1:0] b, input logic [1:0] op,
                                     input logic rw, input logic [1:0] wbs, input logic [1:0] flg);
    return {ctl, pcs, a, b, op, rw, wbs, flg, st};
  endfunction
  function automatic logic [21:0] fe(input logic r);
    return ev(3'd0, {1'b1, 1'b0, 1'b0, r, 1'b0, r}, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0);
  endfunction
  function automatic logic [21:0] de();
    return ev(3'd1, 6'b000010, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0);
  endfunction
  function automatic logic [21:0] ex(input logic [1:0] a, input logic [1:0] b, input logic [1:0] op,
                                     input logic pcw, input logic [1:0] pcs);
    return ev(3'd2, {5'b0, pcw}, pcs, a, b, op, 1'b0, 2'd0, 2'd0);
  endfunction
  function automatic logic [21:0] me(input logic we);
    return ev(3'd3, {1'b1, we, 1'b1, 3'b0}, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0);
  endfunction
  function automatic logic [21:0] wb(input logic [1:0] s);
    return ev(3'd4, 6'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, s, 2'd0);
  endfunction
  function automatic logic [21:0] tr(input logic [1:0] flg);
    return ev(3'd7, 6'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, flg);
  endfunction
  task automatic push(input logic [6:0] o, input logic r, input logic t, input logic [21:0] e);
    sb.push_back('{opc: o, rdy: r, tk: t, exp: e});
  endtask
  task automatic test_reset;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs !== 22'd0) begin failures++; $display("FAIL reset_outputs got=%h exp=%h", obs, 22'd0); end
    @(posedge clk); #1 reset = 1'b0;
  endtask
  task automatic test_addi;
    ent_t c;
    int n = 0;
    push(ADDI, 1'b1, 1'b0, fe(1'b1)); push(ADDI, 1'b1, 1'b0, de());
    push(ADDI, 1'b1, 1'b0, ex(2'd0, 2'd1, 2'd2, 1'b0, 2'd0)); push(ADDI, 1'b1, 1'b0, wb(2'd0));
    while (sb.size() > 0) begin
      c = sb.pop_front(); opcode = c.opc; mem_ready = c.rdy; branch_taken = c.tk;
      @(negedge clk); checks++;
      if (obs !== c.exp) begin failures++; $display("FAIL addi cyc%0d got=%h exp=%h", n, obs, c.exp); end
      n++; @(posedge clk); #1;
    end
  endtask
  task automatic test_load_wait;
    ent_t c;
    int n = 0;
    push(LW, 1'b1, 1'b0, fe(1'b1)); push(LW, 1'b1, 1'b0, de());
    push(LW, 1'b1, 1'b0, ex(2'd0, 2'd1, 2'd0, 1'b0, 2'd0));
    repeat (3) push(LW, 1'b0, 1'b0, me(1'b0));
    push(LW, 1'b1, 1'b0, me(1'b0)); push(LW, 1'b1, 1'b0, wb(2'd1));
    while (sb.size() > 0) begin
      c = sb.pop_front(); opcode = c.opc; mem_ready = c.rdy; branch_taken = c.tk;
      @(negedge clk); checks++;
      if (obs !== c.exp) begin failures++; $display("FAIL load_wait cyc%0d got=%h exp=%h", n, obs, c.exp); end
      n++; @(posedge clk); #1;
    end
  endtask
  task automatic test_store;
    ent_t c;
    int n = 0;
    push(SW, 1'b1, 1'b0, fe(1'b1)); push(SW, 1'b1, 1'b0, de());
    push(SW, 1'b1, 1'b0, ex(2'd0, 2'd1, 2'd0, 1'b0, 2'd0)); push(SW, 1'b1, 1'b0, me(1'b1));
    push(SW, 1'b1, 1'b0, fe(1'b1)); push(ADDI, 1'b1, 1'b0, de());
    push(ADDI, 1'b1, 1'b0, ex(2'd0, 2'd1, 2'd2, 1'b0, 2'd0)); push(ADDI, 1'b1, 1'b0, wb(2'd0));
    while (sb.size() > 0) begin
      c = sb.pop_front(); opcode = c.opc; mem_ready = c.rdy; branch_taken = c.tk;
      @(negedge clk); checks++;
      if (obs !== c.exp) begin failures++; $display("FAIL store cyc%0d got=%h exp=%h", n, obs, c.exp); end
      n++; @(posedge clk); #1;
    end
  endtask
  task automatic test_branch;
    ent_t c;
    int n = 0;
    push(BEQ, 1'b1, 1'b0, fe(1'b1)); push(BEQ, 1'b1, 1'b0, de());
    push(BEQ, 1'b1, 1'b1, ex(2'd0, 2'd0, 2'd1, 1'b0, 2'd0));
    push(BEQ, 1'b1, 1'b0, ex(2'd1, 2'd1, 2'd0, 1'b1, 2'd1));
    push(BEQ, 1'b1, 1'b0, fe(1'b1)); push(BEQ, 1'b1, 1'b0, de());
    push(BEQ, 1'b1, 1'b0, ex(2'd0, 2'd0, 2'd1, 1'b0, 2'd0));
    while (sb.size() > 0) begin
      c = sb.pop_front(); opcode = c.opc; mem_ready = c.rdy; branch_taken = c.tk;
      @(negedge clk); checks++;
      if (obs !== c.exp) begin failures++; $display("FAIL branch cyc%0d got=%h exp=%h", n, obs, c.exp); end
      n++; @(posedge clk); #1;
    end
  endtask
  task automatic test_jumps;
    ent_t c;
    int n = 0;
    push(JAL, 1'b1, 1'b0, fe(1'b1)); push(JAL, 1'b1, 1'b0, de());
    push(JAL, 1'b1, 1'b0, ex(2'd1, 2'd1, 2'd0, 1'b1, 2'd1)); push(JAL, 1'b1, 1'b0, wb(2'd2));
    push(JALR, 1'b1, 1'b0, fe(1'b1)); push(JALR, 1'b1, 1'b0, de());
    push(JALR, 1'b1, 1'b0, ex(2'd0, 2'd1, 2'd0, 1'b1, 2'd2)); push(JALR, 1'b1, 1'b0, wb(2'd2));
    while (sb.size() > 0) begin
      c = sb.pop_front(); opcode = c.opc; mem_ready = c.rdy; branch_taken = c.tk;
      @(negedge clk); checks++;
      if (obs !== c.exp) begin failures++; $display("FAIL jumps cyc%0d got=%h exp=%h", n, obs, c.exp); end
      n++; @(posedge clk); #1;
    end
  endtask
  task automatic test_back_to_back;
    ent_t c;
    int n = 0;
    push(OP, 1'b1, 1'b0, fe(1'b1)); push(OP, 1'b1, 1'b0, de());
    push(OP, 1'b1, 1'b0, ex(2'd0, 2'd0, 2'd2, 1'b0, 2'd0)); push(OP, 1'b1, 1'b0, wb(2'd0));
    push(LUI, 1'b1, 1'b0, fe(1'b1)); push(LUI, 1'b1, 1'b0, de());
    push(LUI, 1'b1, 1'b0, ex(2'd2, 2'd1, 2'd0, 1'b0, 2'd0)); push(LUI, 1'b1, 1'b0, wb(2'd0));
    push(AUIPC, 1'b1, 1'b0, fe(1'b1)); push(AUIPC, 1'b1, 1'b0, de());
    push(AUIPC, 1'b1, 1'b0, ex(2'd1, 2'd1, 2'd0, 1'b0, 2'd0)); push(AUIPC, 1'b1, 1'b0, wb(2'd0));
    push(BEQ, 1'b1, 1'b0, fe(1'b1)); push(BEQ, 1'b1, 1'b0, de());
    push(BEQ, 1'b1, 1'b0, ex(2'd0, 2'd0, 2'd1, 1'b0, 2'd0));
    while (sb.size() > 0) begin
      c = sb.pop_front(); opcode = c.opc; mem_ready = c.rdy; branch_taken = c.tk;
      @(negedge clk); checks++;
      if (obs !== c.exp) begin failures++; $display("FAIL back_to_back cyc%0d got=%h exp=%h", n, obs, c.exp); end
      n++; @(posedge clk); #1;
    end
  endtask
  task automatic test_illegal;
    ent_t c;
    int n = 0;
    push(BAD, 1'b1, 1'b0, fe(1'b1)); push(BAD, 1'b1, 1'b0, de());
    repeat (20) push(BAD, 1'b1, 1'b1, tr(2'b10));
    while (sb.size() > 0) begin
      c = sb.pop_front(); opcode = c.opc; mem_ready = c.rdy; branch_taken = c.tk;
      @(negedge clk); checks++;
      if (obs !== c.exp) begin failures++; $display("FAIL illegal cyc%0d got=%h exp=%h", n, obs, c.exp); end
      n++; @(posedge clk); #1;
    end
    reset = 1'b1; #1;
    checks++;
    if (obs !== 22'd0) begin failures++; $display("FAIL illegal_reset got=%h exp=%h", obs, 22'd0); end
    @(posedge clk); #1 reset = 1'b0; branch_taken = 1'b0;
  endtask
  task automatic test_fetch_timeout;
    ent_t c;
    int n = 0;
    repeat (16) push(ADDI, 1'b0, 1'b0, fe(1'b0));
    repeat (3) push(ADDI, 1'b1, 1'b0, tr(2'b01));
    while (sb.size() > 0) begin
      c = sb.pop_front(); opcode = c.opc; mem_ready = c.rdy; branch_taken = c.tk;
      @(negedge clk); checks++;
      if (obs !== c.exp) begin failures++; $display("FAIL fetch_timeout cyc%0d got=%h exp=%h", n, obs, c.exp); end
      n++; @(posedge clk); #1;
    end
    reset = 1'b1; #1;
    checks++;
    if (obs !== 22'd0) begin failures++; $display("FAIL timeout_reset got=%h exp=%h", obs, 22'd0); end
    @(posedge clk); #1 reset = 1'b0;
  endtask
  task automatic test_reset_mid_store;
    ent_t c;
    int n = 0;
    push(SW, 1'b1, 1'b0, fe(1'b1)); push(SW, 1'b1, 1'b0, de());
    push(SW, 1'b1, 1'b0, ex(2'd0, 2'd1, 2'd0, 1'b0, 2'd0)); push(SW, 1'b0, 1'b0, me(1'b1));
    while (sb.size() > 0) begin
      c = sb.pop_front(); opcode = c.opc; mem_ready = c.rdy; branch_taken = c.tk;
      @(negedge clk); checks++;
      if (obs !== c.exp) begin failures++; $display("FAIL reset_store cyc%0d got=%h exp=%h", n, obs, c.exp); end
      n++; @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_store_we got=%b exp=0", mem_we); end
    checks++;
    if (state_o !== 3'd0 || obs !== 22'd0) begin failures++; $display("FAIL reset_store_state got=%h exp=%h", obs, 22'd0); end
    @(posedge clk); #1 reset = 1'b0;
  endtask
  initial begin
    test_reset;
    test_addi;
    test_load_wait;
    test_store;
    test_branch;
    test_jumps;
    test_illegal;
    test_fetch_timeout;
    test_reset_mid_store;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
